// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and widths for the iterative unsigned multiplier
package mul_pkg;

   localparam int MUL_WIDTH = 32;
   localparam int PW        = 2 * MUL_WIDTH;
   localparam int SAW       = 2 * MUL_WIDTH - 1;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_RUN  = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_e;

endpackage

// File: rtl/mul_step_adder.sv
// rtl/mul_step_adder.sv - SAW-bit unsigned ripple-carry adder, carry-out on the top bit
module mul_step_adder #(
   parameter int SAW = mul_pkg::SAW
) (
   input  logic [SAW-1:0] i_a,
   input  logic [SAW-1:0] i_b,
   output logic [SAW:0]   o_sum
);

   logic w_carry;

   always_comb begin
      w_carry = 1'b0;
      o_sum   = '0;
      for (int i = 0; i < SAW; i++) begin
         o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
         w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
      end
      o_sum[SAW] = w_carry;
   end

endmodule

// File: rtl/mul_iterative_u32.sv
// rtl/mul_iterative_u32.sv - shift-and-add multiplier, one multiplier bit per cycle
module mul_iterative_u32
   import mul_pkg::*;
#(
   parameter int WIDTH      = MUL_WIDTH,
   parameter bit EARLY_TERM = 1'b0
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_in_valid,
   output logic                 o_in_ready,
   input  logic [WIDTH-1:0]     i_op_a,
   input  logic [WIDTH-1:0]     i_op_b,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic [2*WIDTH-1:0]   o_product,
   output logic                 o_busy
);

   localparam int P  = (PW / MUL_WIDTH) * WIDTH;
   localparam int SA = P - 1;
   localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

   mul_state_e       r_state;
   logic [SA-1:0]    r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [P-1:0]     r_acc;
   logic [SW-1:0]    r_step;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_busy;
   logic [P-1:0]     r_product;

   logic [SA-1:0]    w_addend;
   logic [P-1:0]     w_sum;
   logic [WIDTH-1:0] w_mplier_next;
   logic             w_last;

   assign w_addend      = r_mplier[0] ? r_mcand : '0;
   assign w_mplier_next = r_mplier >> 1;
   assign w_last        = (r_step == LAST_STEP) || (EARLY_TERM && (w_mplier_next == '0));

   // acc bit P-1 comes only from the carry; the product never exceeds P bits
   mul_step_adder #(.SAW(SA)) u_step_adder (
      .i_a   (r_acc[SA-1:0]),
      .i_b   (w_addend),
      .o_sum (w_sum)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= MUL_IDLE;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_acc       <= '0;
         r_step      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_product   <= '0;
      end else begin
         case (r_state)
            MUL_IDLE: begin
               if (i_in_valid) begin
                  r_mcand    <= {{(SA-WIDTH){1'b0}}, i_op_a};
                  r_mplier   <= i_op_b;
                  r_acc      <= '0;
                  r_step     <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= MUL_RUN;
               end
            end
            MUL_RUN: begin
               r_acc    <= w_sum;
               r_mcand  <= r_mcand << 1;
               r_mplier <= w_mplier_next;
               r_step   <= r_step + 1'b1;
               if (w_last) begin
                  r_product   <= w_sum;
                  r_out_valid <= 1'b1;
                  r_state     <= MUL_DONE;
               end
            end
            MUL_DONE: begin
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= MUL_IDLE;
               end
            end
            default: begin
               r_state     <= MUL_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_busy      = r_busy;
   assign o_product   = r_product;

endmodule

// File: tb/tb_mul_iterative_u32.sv
// tb/tb_mul_iterative_u32.sv - directed and random checks of fixed-latency and early-term multipliers
module tb_mul_iterative_u32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid  [2];
   logic        out_ready [2];
   logic        in_ready  [2];
   logic        out_valid [2];
   logic        busy      [2];
   logic [31:0] op_a      [2];
   logic [31:0] op_b      [2];
   logic [63:0] product   [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mul_iterative_u32 #(.WIDTH(32), .EARLY_TERM(1'b0)) u_fixed (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_in_valid  (in_valid[0]),
      .o_in_ready  (in_ready[0]),
      .i_op_a      (op_a[0]),
      .i_op_b      (op_b[0]),
      .o_out_valid (out_valid[0]),
      .i_out_ready (out_ready[0]),
      .o_product   (product[0]),
      .o_busy      (busy[0])
   );

   mul_iterative_u32 #(.WIDTH(32), .EARLY_TERM(1'b1)) u_early (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_in_valid  (in_valid[1]),
      .o_in_ready  (in_ready[1]),
      .i_op_a      (op_a[1]),
      .i_op_b      (op_b[1]),
      .o_out_valid (out_valid[1]),
      .i_out_ready (out_ready[1]),
      .o_product   (product[1]),
      .o_busy      (busy[1])
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Latency counts edges from the accepting edge (1) to the edge after which out_valid is high.
   task automatic run_op(input int u, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input int pulse_at,
                         output int lat, output logic [63:0] prod);
      logic        bad;
      logic [63:0] held;
      @(negedge clk);
      check("accept_ready", 64'(in_ready[u]), 64'd1);
      in_valid[u]  = 1'b1;
      op_a[u]      = a;
      op_b[u]      = b;
      out_ready[u] = 1'b0;
      @(negedge clk);
      in_valid[u] = 1'b0;
      lat = 1;
      bad = 1'b0;
      while (!out_valid[u] && lat < 200) begin
         if (in_ready[u] || !busy[u]) bad = 1'b1;
         if (lat == pulse_at) begin
            in_valid[u] = 1'b1;
            op_a[u]     = 32'd7;
            op_b[u]     = 32'd7;
         end else begin
            in_valid[u] = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      in_valid[u] = 1'b0;
      check("run_in_ready_low", 64'(bad), 64'd0);
      check("done_in_ready_low", 64'(in_ready[u]), 64'd0);
      held = product[u];
      bad  = 1'b0;
      repeat (hold) begin
         @(negedge clk);
         if (product[u] !== held || !out_valid[u] || in_ready[u] || !busy[u]) bad = 1'b1;
      end
      check("hold_stable", 64'(bad), 64'd0);
      prod = held;
      out_ready[u] = 1'b1;
      @(negedge clk);
      out_ready[u] = 1'b0;
      check("single_xfer_valid", 64'(out_valid[u]), 64'd0);
      check("single_xfer_ready", 64'(in_ready[u]), 64'd1);
      @(negedge clk);
      check("no_dup_valid", 64'(out_valid[u]), 64'd0);
   endtask

   int          lat;
   logic [63:0] p;
   logic [31:0] ra, rb;
   int          exp_lat;
   int          u;

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid[k]  = 1'b0;
         out_ready[k] = 1'b0;
         op_a[k]      = '0;
         op_b[k]      = '0;
      end
      repeat (2) @(negedge clk);
      check("rst_in_ready", 64'(in_ready[0]), 64'd1);
      check("rst_out_valid", 64'(out_valid[0]), 64'd0);
      check("rst_busy", 64'(busy[0]), 64'd0);
      check("rst_product", product[0], 64'd0);
      rst_n = 1'b1;

      run_op(0, 32'd3, 32'd5, 0, -1, lat, p);
      check("basic_prod", p, 64'd15);
      check("basic_lat", 64'(lat), 64'd33);

      run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, lat, p);
      check("max_prod", p, 64'hFFFF_FFFE_0000_0001);
      check("max_lat", 64'(lat), 64'd33);

      run_op(0, 32'h1234_5678, 32'h9ABC_DEF0, 10, 12, lat, p);
      check("bp_prod", p, 64'h0B00_EA4E_242D_2080);
      check("bp_lat", 64'(lat), 64'd33);

      run_op(1, 32'hDEAD_BEEF, 32'd0, 0, -1, lat, p);
      check("et_zero_prod", p, 64'd0);
      check("et_zero_lat", 64'(lat), 64'd2);

      run_op(1, 32'hDEAD_BEEF, 32'd1, 0, -1, lat, p);
      check("et_one_prod", p, 64'h0000_0000_DEAD_BEEF);
      check("et_one_lat", 64'(lat), 64'd2);

      run_op(1, 32'd3, 32'd5, 2, 2, lat, p);
      check("et_five_prod", p, 64'd15);
      check("et_five_lat", 64'(lat), 64'd4);

      run_op(1, 32'hFFFF_FFFF, 32'h8000_0000, 0, -1, lat, p);
      check("et_top_prod", p, 64'h7FFF_FFFF_8000_0000);
      check("et_top_lat", 64'(lat), 64'd33);

      // abort a run at step 17 with an asynchronous reset
      @(negedge clk);
      in_valid[0] = 1'b1;
      op_a[0]     = 32'h1234_5678;
      op_b[0]     = 32'h9ABC_DEF0;
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (17) @(negedge clk);
      check("pre_rst_busy", 64'(busy[0]), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(out_valid[0]), 64'd0);
      check("mid_rst_product", product[0], 64'd0);
      check("mid_rst_in_ready", 64'(in_ready[0]), 64'd1);
      check("mid_rst_busy", 64'(busy[0]), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_op(0, 32'd6, 32'd7, 0, -1, lat, p);
      check("post_rst_prod", p, 64'd42);
      check("post_rst_lat", 64'(lat), 64'd33);

      for (int i = 0; i < 160; i++) begin
         u  = i % 2;
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         if ((i % 17) == 3) rb = 32'd0;
         if (u == 0) begin
            exp_lat = 33;
         end else begin
            exp_lat = 2;
            for (int k = 0; k < 32; k++) if (rb[k]) exp_lat = k + 2;
         end
         run_op(u, ra, rb, $urandom_range(0, 3), $urandom_range(1, 40), lat, p);
         check("rand_prod", p, 64'(ra) * 64'(rb));
         check("rand_lat", 64'(lat), 64'(exp_lat));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
